scaler_v_round_pack: RTL and testbench

//   Downstream stage of the vertical scaler DSP array. Takes KERNEL_MAX signed VRLT_BITWIDTH

---
 rtl/scaler_v_round_pack.sv | 221 ++++++++++++++++++++++
 tb/tb_scaler_v_round_pack.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_v_round_pack.sv
// -----------------------------------------------------------------------------
// scaler_v_round_pack
//   Back end of the vertical scaler DSP array. Each input beat carries
//   KERNEL_MAX signed accumulator results in the coefficient fixed-point
//   domain. Every lane is rounded half-up, shifted down by FRAC_BITS and
//   clamped to an unsigned pixel. The lanes are then packed into one word and
//   buffered in a first-word-fall-through FIFO with a valid/ready output.
//   The DSP array cannot be stalled, so this block raises an early almost-full
//   flag and reports any beat lost to overflow through a sticky error bit.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   din_en     in   input beat valid (no back-pressure)
//   din_last   in   end-of-line tag, travels with its beat
//   din_result in   KERNEL_MAX signed results, lane k at [VRLT*(k+1)-1:VRLT*k]
//   din_afull  out  registered almost-full; upstream must stop issuing beats
//   dout_valid out  output beat available (FIFO not empty)
//   dout_ready in   consumer accepts the beat when valid & ready
//   dout_last  out  end-of-line tag of the head beat
//   dout_pixel out  KERNEL_MAX packed pixels, lane k at [PIX*(k+1)-1:PIX*k]
//   ovf_err    out  sticky: a beat was dropped because the FIFO was full
//   err_clr    in   synchronous clear of ovf_err (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module scaler_v_round_pack #(
  parameter int PIXEL_BITWIDTH = 8,
  parameter int KERNEL_MAX     = 4,
  parameter int VRLT_BITWIDTH  = 18,
  parameter int FRAC_BITS      = 6,
  parameter int FIFO_DEPTH     = 16,
  parameter int AFULL_MARGIN   = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                din_en,
  input  logic                                din_last,
  input  logic [VRLT_BITWIDTH*KERNEL_MAX-1:0]  din_result,
  output logic                                din_afull,
  output logic                                dout_valid,
  input  logic                                dout_ready,
  output logic                                dout_last,
  output logic [PIXEL_BITWIDTH*KERNEL_MAX-1:0] dout_pixel,
  output logic                                ovf_err,
  input  logic                                err_clr
);

  // One guard bit above the input width so adding the rounding constant can
  // never wrap the most positive result into a negative value.
  localparam int SUM_W    = VRLT_BITWIDTH + 1;
  localparam int PIXW     = PIXEL_BITWIDTH * KERNEL_MAX;
  localparam int ENT_W    = PIXW + 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int OCC_W    = CNT_W + 1;
  localparam int AFULL_TH = FIFO_DEPTH - AFULL_MARGIN;

  localparam logic [SUM_W-1:0] ROUND_HALF = {{(SUM_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_TH     = OCC_W'(AFULL_TH);

  // Arithmetic shift of the rounded sum, then saturate to the pixel range.
  // A set sign bit means a negative pixel; any set bit between the sign and
  // the pixel field means the value exceeds the largest pixel.
  function automatic logic [PIXEL_BITWIDTH-1:0] round_clamp(input logic [SUM_W-1:0] sum);
    logic signed [SUM_W-1:0] q;
    logic [PIXEL_BITWIDTH-1:0] pix;
    q = $signed(sum) >>> FRAC_BITS;
    if (q[SUM_W-1]) begin
      pix = '0;
    end else if (|q[SUM_W-2:PIXEL_BITWIDTH]) begin
      pix = '1;
    end else begin
      pix = q[PIXEL_BITWIDTH-1:0];
    end
    return pix;
  endfunction

  // Input capture stage (boundary register towards the DSP array).
  logic                               r_s0_valid;
  logic                               r_s0_last;
  logic [VRLT_BITWIDTH*KERNEL_MAX-1:0] r_s0_res;

  // Rounding stage.
  logic                   r_s1_valid;
  logic                   r_s1_last;
  logic [SUM_W-1:0]       r_s1_sum [KERNEL_MAX];
  logic [SUM_W-1:0]       w_s1_sum [KERNEL_MAX];

  // Shift/clamp stage; its valid is the FIFO push request.
  logic                   r_s2_valid;
  logic                   r_s2_last;
  logic [PIXW-1:0]        r_s2_pix;
  logic [PIXW-1:0]        w_s2_pix;

  // FIFO state and registered head.
  logic [ENT_W-1:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_dout_valid;
  logic                   r_dout_last;
  logic [PIXW-1:0]        r_dout_pixel;
  logic                   r_afull;
  logic                   r_ovf;

  logic                   w_pop;
  logic                   w_full;
  logic                   w_push;
  logic                   w_drop;
  logic [PTR_W-1:0]       w_wr_ptr_nxt;
  logic [PTR_W-1:0]       w_rd_ptr_nxt;
  logic [CNT_W-1:0]       w_count_nxt;
  logic [ENT_W-1:0]       w_head_nxt;
  logic [OCC_W-1:0]       w_occ;
  logic                   w_afull_nxt;

  // Per-lane sign extension plus half an output LSB (round half up).
  always_comb begin
    for (int k = 0; k < KERNEL_MAX; k++) begin
      w_s1_sum[k] = {r_s0_res[k*VRLT_BITWIDTH + VRLT_BITWIDTH - 1],
                     r_s0_res[k*VRLT_BITWIDTH +: VRLT_BITWIDTH]} + ROUND_HALF;
    end
  end

  // Per-lane shift and clamp, packed into the output word.
  always_comb begin
    w_s2_pix = '0;
    for (int k = 0; k < KERNEL_MAX; k++) begin
      w_s2_pix[k*PIXEL_BITWIDTH +: PIXEL_BITWIDTH] = round_clamp(r_s1_sum[k]);
    end
  end

  // FIFO control: push/pop/drop decisions, next pointers and next head word.
  always_comb begin
    w_pop        = r_dout_valid & dout_ready;
    w_full       = (r_count == CNT_FULL);
    // When full, a push is only possible if the same edge frees a slot.
    w_push       = r_s2_valid & (~w_full | w_pop);
    w_drop       = r_s2_valid & w_full & ~w_pop;
    w_wr_ptr_nxt = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
    w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
    // The entry being written this edge is not yet in memory; bypass it when
    // it becomes the new head (empty FIFO, or last entry popped while pushing).
    if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
      w_head_nxt = {r_s2_last, r_s2_pix};
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
    // Beats still in the rounding and clamp stages are counted as occupied.
    w_occ       = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid} + {{CNT_W{1'b0}}, r_s2_valid};
    w_afull_nxt = (w_occ >= OCC_TH);
  end

  // Pipeline valids, FIFO state and all outputs; cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_valid   <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
      r_dout_pixel <= '0;
      r_afull      <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_s0_valid   <= din_en;
      r_s1_valid   <= r_s0_valid;
      r_s2_valid   <= r_s1_valid;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
      r_dout_valid <= (w_count_nxt != '0);
      // Head only reloads when there is an entry, so it holds under stall.
      if (w_count_nxt != '0) begin
        {r_dout_last, r_dout_pixel} <= w_head_nxt;
      end
      r_afull      <= w_afull_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (err_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Datapath registers; qualified by their valids, so no reset needed.
  always_ff @(posedge clk) begin
    if (din_en) begin
      r_s0_res  <= din_result;
      r_s0_last <= din_last;
    end
    if (r_s0_valid) begin
      r_s1_sum  <= w_s1_sum;
      r_s1_last <= r_s0_last;
    end
    if (r_s1_valid) begin
      r_s2_pix  <= w_s2_pix;
      r_s2_last <= r_s1_last;
    end
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_s2_last, r_s2_pix};
    end
  end

  assign din_afull  = r_afull;
  assign dout_valid = r_dout_valid;
  assign dout_last  = r_dout_last;
  assign dout_pixel = r_dout_pixel;
  assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_scaler_v_round_pack.sv
// Self-checking bench for scaler_v_round_pack: expected beats are queued at
// issue time and a negedge monitor compares every accepted output beat.
module tb_scaler_v_round_pack;

  localparam int PIX = 8;
  localparam int K   = 4;
  localparam int VW  = 18;
  localparam int EW  = PIX*K + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            din_en;
  logic            din_last;
  logic [VW*K-1:0] din_result;
  logic            din_afull;
  logic            dout_valid;
  logic            dout_ready;
  logic            dout_last;
  logic [PIX*K-1:0] dout_pixel;
  logic            ovf_err;
  logic            err_clr;

  int n_total = 0;
  int n_pass  = 0;
  int next_id = 0;
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] mon_e;

  always #5 clk = ~clk;

  scaler_v_round_pack dut (
    .clk        (clk),
    .rst        (rst),
    .din_en     (din_en),
    .din_last   (din_last),
    .din_result (din_result),
    .din_afull  (din_afull),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .dout_pixel (dout_pixel),
    .ovf_err    (ovf_err),
    .err_clr    (err_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Scoreboard monitor: a beat shown with valid & ready is accepted at the next edge.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: got %0h with no beat expected", {dout_last, dout_pixel});
      end else begin
        mon_e = exp_q.pop_front();
        check("beat", 64'({dout_last, dout_pixel}), 64'(mon_e));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [VW*K-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [VW*K-1:0] r;
    r = {VW'(d), VW'(c), VW'(b), VW'(a)};
    return r;
  endfunction

  // Lane k of beat id holds pixel value (4*id+k)%256 scaled by 64, with
  // offsets +31 and -32 on lanes 1 and 2 that must round back to it.
  function automatic logic [VW*K-1:0] mk_res(input int id);
    logic [VW*K-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < K; k++) begin
      v = ((id*4 + k) % 256) * 64;
      if (k == 1) v = v + 31;
      else if (k == 2) v = v - 32;
      r[k*VW +: VW] = VW'(v);
    end
    return r;
  endfunction

  function automatic logic [PIX*K-1:0] mk_pix(input int id);
    logic [PIX*K-1:0] p;
    p = '0;
    for (int k = 0; k < K; k++) p[k*PIX +: PIX] = PIX'((id*4 + k) % 256);
    return p;
  endfunction

  task automatic send(input logic [VW*K-1:0] res, input logic last,
                      input logic [PIX*K-1:0] pix, input bit kept);
    din_en     = 1'b1;
    din_last   = last;
    din_result = res;
    if (kept) exp_q.push_back({last, pix});
    tick();
    din_en   = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic send_id(input bit kept);
    int id;
    id = next_id;
    next_id++;
    send(mk_res(id), (id % 32) == 31, mk_pix(id), kept);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int afull_at;
    int extra;
    rst        = 1'b1;
    din_en     = 1'b0;
    din_last   = 1'b0;
    din_result = '0;
    dout_ready = 1'b1;
    err_clr    = 1'b0;
    idle(2);
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_last",  64'(dout_last),  64'd0);
    check("rst_pixel", 64'(dout_pixel), 64'd0);
    check("rst_afull", 64'(din_afull),  64'd0);
    check("rst_ovf",   64'(ovf_err),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Rounding/clamp and latency: lanes {0,31,32,-33} -> {0,0,1,0}.
    send(pack4(0, 31, 32, -33), 1'b0, 32'h0001_0000, 1'b1);
    check("lat_n0", 64'(dout_valid), 64'd0);
    tick();
    check("lat_n1", 64'(dout_valid), 64'd0);
    tick();
    check("lat_n2", 64'(dout_valid), 64'd0);
    tick();
    check("lat_n3", 64'(dout_valid), 64'd1);
    send(pack4(16383, 16352, 16351, -1), 1'b1, 32'h00FF_FFFF, 1'b1);
    send(pack4(95, 96, 0, 0), 1'b0, 32'h0000_0201, 1'b1);
    drain("round_drain");

    // Streaming: 64 beats back-to-back, last on beats 31 and 63, no gaps.
    next_id = 0;
    for (int i = 0; i < 64; i++) send_id(1'b1);
    idle(4);
    check("stream_no_gap", 64'(exp_q.size()), 64'd0);
    check("stream_ovf", 64'(ovf_err), 64'd0);
    idle(2);

    // Back-pressure: the source stops two beats after seeing din_afull.
    dout_ready = 1'b0;
    afull_at   = -1;
    extra      = 0;
    for (int t = 0; t < 40; t++) begin
      if (afull_at < 0 && din_afull) afull_at = t;
      if (afull_at >= 0) begin
        if (extra >= 2) break;
        extra++;
      end
      send_id(1'b1);
    end
    check("afull_rise_beats", 64'(afull_at), 64'd12);
    idle(6);
    check("bp_afull_held", 64'(din_afull), 64'd1);
    check("bp_no_drop", 64'(ovf_err), 64'd0);
    dout_ready = 1'b1;
    drain("bp_drain");
    idle(4);
    check("afull_fall", 64'(din_afull), 64'd0);

    // Overflow: 20 beats into a stalled FIFO, the last 4 are dropped.
    dout_ready = 1'b0;
    for (int i = 0; i < 20; i++) send_id(i < 16);
    idle(4);
    check("ovf_set", 64'(ovf_err), 64'd1);
    idle(5);
    check("ovf_sticky", 64'(ovf_err), 64'd1);
    // A new drop lands on the same edge as err_clr: set wins.
    send_id(1'b0);
    idle(2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_clr_vs_drop", 64'(ovf_err), 64'd1);
    idle(2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_clear", 64'(ovf_err), 64'd0);
    dout_ready = 1'b1;
    drain("ovf_drain");
    idle(3);

    // Full FIFO with simultaneous push and pop: nothing may be lost.
    dout_ready = 1'b0;
    for (int t = 0; t < 40; t++) begin
      send_id(1'b1);
      if (t == 18) dout_ready = 1'b1;
    end
    drain("fullpp_drain");
    check("fullpp_no_drop", 64'(ovf_err), 64'd0);
    idle(3);

    // Reset mid-stream: 5 beats buffered, 2 in flight.
    dout_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_id(1'b1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(dout_valid), 64'd0);
    check("midrst_afull", 64'(din_afull), 64'd0);
    check("midrst_pixel", 64'(dout_pixel), 64'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dout_ready = 1'b1;
    idle(6);
    check("midrst_flushed", 64'(dout_valid), 64'd0);
    next_id = 200;
    send_id(1'b1);
    send_id(1'b1);
    drain("post_reset_drain");

    idle(3);
    check("end_valid", 64'(dout_valid), 64'd0);
    check("end_queue", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
